// File: rtl/lcd_timing_driver.sv
// RGB-LCD timing generator: h/v counters, registered sync/DE/coordinate outputs, pixel bus gated by DE.
// Coordinates lead lcd_de by PIX_LAT cycles so a PIX_LAT-deep content pipeline lines up with the panel.
module lcd_timing_driver #(
    parameter int H_SYNC  = 41,
    parameter int H_BACK  = 2,
    parameter int H_DISP  = 480,
    parameter int H_FRONT = 2,
    parameter int V_SYNC  = 10,
    parameter int V_BACK  = 2,
    parameter int V_DISP  = 272,
    parameter int V_FRONT = 2,
    parameter int PIX_LAT = 2
) (
    input  logic        lcd_pclk,
    input  logic        rst,
    input  logic [23:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [23:0] lcd_rgb,
    output logic        lcd_bl,
    output logic        frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int HA      = H_SYNC + H_BACK;
    localparam int VA      = V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_SYNC_C  = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_C  = 11'(V_SYNC);
    localparam logic [10:0] HA_C      = 11'(HA);
    localparam logic [10:0] HE_C      = 11'(HA + H_DISP);
    localparam logic [10:0] VA_C      = 11'(VA);
    localparam logic [10:0] VE_C      = 11'(VA + V_DISP);
    // Request window is evaluated on h+PIX_LAT (one extra bit) so a zero lower bound never arises.
    localparam logic [11:0] PIX_LAT_C = 12'(PIX_LAT);
    localparam logic [11:0] HA_W      = 12'(HA);
    localparam logic [11:0] HE_W      = 12'(HA + H_DISP);

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic [10:0] xpos_q, xpos_d;
    logic [10:0] ypos_q, ypos_d;
    logic        fs_q, fs_d;
    logic        bl_q;

    logic        h_wrap;
    logic        line_act;
    logic        req_win;
    logic [11:0] h_ahead;

    always_comb begin
        h_wrap   = (h_cnt_q == H_LAST);
        h_cnt_d  = h_wrap ? 11'd0 : h_cnt_q + 11'd1;
        v_cnt_d  = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
        end

        line_act = (v_cnt_q >= VA_C) && (v_cnt_q < VE_C);
        h_ahead  = {1'b0, h_cnt_q} + PIX_LAT_C;
        req_win  = line_act && (h_ahead >= HA_W) && (h_ahead < HE_W);

        hs_d     = !(h_cnt_q < H_SYNC_C);
        vs_d     = !(v_cnt_q < V_SYNC_C);
        de_d     = (h_cnt_q >= HA_C) && (h_cnt_q < HE_C) && line_act;
        xpos_d   = req_win ? 11'(h_ahead - HA_W) : 11'd0;
        ypos_d   = line_act ? (v_cnt_q - VA_C) : 11'd0;
        fs_d     = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
    end

    // Reset aborts the frame outright; the first edge after release shows position (0,0).
    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            h_cnt_q <= 11'd0;
            v_cnt_q <= 11'd0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            de_q    <= 1'b0;
            xpos_q  <= 11'd0;
            ypos_q  <= 11'd0;
            fs_q    <= 1'b0;
            bl_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            fs_q    <= fs_d;
            bl_q    <= 1'b1;
        end
    end

    assign pixel_xpos  = xpos_q;
    assign pixel_ypos  = ypos_q;
    assign lcd_hs      = hs_q;
    assign lcd_vs      = vs_q;
    assign lcd_de      = de_q;
    assign lcd_bl      = bl_q;
    assign frame_start = fs_q;
    assign lcd_rgb     = de_q ? pixel_data : 24'h0;

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Directed bench: default build through the first active line plus a mid-video reset,
// PIX_LAT=0 / PIX_LAT=43 builds for request alignment, and a shrunken build for whole-frame wrap.
module tb_lcd_timing_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] zero_dat = 24'h0;
    always #5 clk = ~clk;

    // Main instance, default parameters, fed by a 2-stage content pipeline model.
    logic [10:0] m_x, m_y;
    logic        m_hs, m_vs, m_de, m_bl, m_fs;
    logic [23:0] m_rgb, pipe1, pipe2;

    always @(posedge clk) begin
        pipe1 <= {m_x[7:0], m_y[7:0], 8'hA5};
        pipe2 <= pipe1;
    end

    lcd_timing_driver u_dut (
        .lcd_pclk(clk), .rst(rst), .pixel_data(pipe2),
        .pixel_xpos(m_x), .pixel_ypos(m_y), .lcd_hs(m_hs), .lcd_vs(m_vs),
        .lcd_de(m_de), .lcd_rgb(m_rgb), .lcd_bl(m_bl), .frame_start(m_fs)
    );

    logic [10:0] z_x, z_y;
    logic        z_hs, z_vs, z_de, z_bl, z_fs;
    logic [23:0] z_rgb;
    lcd_timing_driver #(.PIX_LAT(0)) u_lat0 (
        .lcd_pclk(clk), .rst(rst), .pixel_data(zero_dat),
        .pixel_xpos(z_x), .pixel_ypos(z_y), .lcd_hs(z_hs), .lcd_vs(z_vs),
        .lcd_de(z_de), .lcd_rgb(z_rgb), .lcd_bl(z_bl), .frame_start(z_fs)
    );

    logic [10:0] f_x, f_y;
    logic        f_hs, f_vs, f_de, f_bl, f_fs;
    logic [23:0] f_rgb;
    lcd_timing_driver #(.PIX_LAT(43)) u_lat43 (
        .lcd_pclk(clk), .rst(rst), .pixel_data(zero_dat),
        .pixel_xpos(f_x), .pixel_ypos(f_y), .lcd_hs(f_hs), .lcd_vs(f_vs),
        .lcd_de(f_de), .lcd_rgb(f_rgb), .lcd_bl(f_bl), .frame_start(f_fs)
    );

    // 16 x 10 frame (160 cycles) so full-frame wrap is reachable in a short run.
    logic [10:0] s_x, s_y;
    logic        s_hs, s_vs, s_de, s_bl, s_fs;
    logic [23:0] s_rgb;
    lcd_timing_driver #(
        .H_SYNC(4), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_DISP(4), .V_FRONT(2), .PIX_LAT(2)
    ) u_small (
        .lcd_pclk(clk), .rst(rst), .pixel_data(zero_dat),
        .pixel_xpos(s_x), .pixel_ypos(s_y), .lcd_hs(s_hs), .lcd_vs(s_vs),
        .lcd_de(s_de), .lcd_rgb(s_rgb), .lcd_bl(s_bl), .frame_start(s_fs)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_hs"}, 32'(m_hs), 32'd1);
        check({tag, "_vs"}, 32'(m_vs), 32'd1);
        check({tag, "_de"}, 32'(m_de), 32'd0);
        check({tag, "_x"},  32'(m_x), 32'd0);
        check({tag, "_y"},  32'(m_y), 32'd0);
        check({tag, "_fs"}, 32'(m_fs), 32'd0);
        check({tag, "_bl"}, 32'(m_bl), 32'd0);
        check({tag, "_rgb"}, 32'(m_rgb), 32'd0);
    endtask

    initial begin
        int h, v, hs16, v10;
        int hs_err, vs_low, de_err, rgb_err, xy_err, fs_cnt, z_err, f_err, s_err, s_fs_cnt;
        int hs_low_line0, first_vs_hi, first_de, first_x1, z_first_x1, f_first_x1;
        logic        exp_de;
        logic [10:0] exp_x;
        logic [23:0] first_rgb, last_rgb;

        hs_err = 0; vs_low = 0; de_err = 0; rgb_err = 0; xy_err = 0; fs_cnt = 0;
        z_err = 0; f_err = 0; s_err = 0; s_fs_cnt = 0; hs_low_line0 = 0;
        first_vs_hi = -1; first_de = -1; first_x1 = -1; z_first_x1 = -1; f_first_x1 = -1;
        first_rgb = 24'h0; last_rgb = 24'h0;

        repeat (5) @(negedge clk);
        check_reset_state("rst_hold");

        rst = 1'b0;
        @(negedge clk);
        check("rel_fs", 32'(m_fs), 32'd1);
        check("rel_hs", 32'(m_hs), 32'd0);
        check("rel_vs", 32'(m_vs), 32'd0);
        check("rel_bl", 32'(m_bl), 32'd1);
        check("rel_de", 32'(m_de), 32'd0);

        // Walk lines 0..12 of the default frame; position p is what the outputs currently show.
        for (int p = 0; p < 13 * 525; p++) begin
            h = p % 525;
            v = p / 525;
            if (m_hs !== (h >= 41)) hs_err++;
            if (v == 0 && !m_hs) hs_low_line0++;
            if (!m_vs) vs_low++;
            if (m_vs && first_vs_hi < 0) first_vs_hi = p;
            if (m_fs) fs_cnt++;

            exp_de = (v >= 12) && (h >= 43) && (h < 523);
            if (m_de !== exp_de) de_err++;
            if (m_de && first_de < 0) begin
                first_de  = p;
                first_rgb = m_rgb;
            end
            if (p == 12 * 525 + 522) last_rgb = m_rgb;
            if (exp_de) begin
                if (m_rgb !== {8'(h - 43), 8'h00, 8'hA5}) rgb_err++;
            end else if (m_rgb !== 24'h0) rgb_err++;

            exp_x = (v == 12 && h >= 41 && h < 521) ? 11'(h - 41) : 11'd0;
            if (m_x !== exp_x || m_y !== 11'd0) xy_err++;
            if (m_x == 11'd1 && first_x1 < 0) first_x1 = p;

            exp_x = (v == 12 && h >= 43 && h < 523) ? 11'(h - 43) : 11'd0;
            if (z_x !== exp_x || z_de !== exp_de) z_err++;
            if (z_x == 11'd1 && z_first_x1 < 0) z_first_x1 = p;

            exp_x = (v == 12 && h < 480) ? 11'(h) : 11'd0;
            if (f_x !== exp_x || f_de !== exp_de) f_err++;
            if (f_x == 11'd1 && f_first_x1 < 0) f_first_x1 = p;

            hs16 = p % 16;
            v10  = (p / 16) % 10;
            if (s_de !== (hs16 >= 6 && hs16 < 14 && v10 >= 4 && v10 < 8)) s_err++;
            if (s_fs !== (p % 160 == 0)) s_err++;
            if (s_fs) s_fs_cnt++;

            @(negedge clk);
        end

        check("hs_pattern_errs", 32'(hs_err), 32'd0);
        check("hs_low_line0", 32'(hs_low_line0), 32'd41);
        check("vs_low_cycles", 32'(vs_low), 32'd5250);
        check("vs_first_high_p", 32'(first_vs_hi), 32'd5250);
        check("fs_count", 32'(fs_cnt), 32'd1);
        check("de_pattern_errs", 32'(de_err), 32'd0);
        check("de_first_p", 32'(first_de), 32'd6343);
        check("xpos1_first_p", 32'(first_x1), 32'd6342);
        check("xy_errs", 32'(xy_err), 32'd0);
        check("rgb_errs", 32'(rgb_err), 32'd0);
        check("rgb_first", 32'(first_rgb), 32'h0000A5);
        check("rgb_last_line12", 32'(last_rgb), 32'hDF00A5);
        check("lat0_errs", 32'(z_err), 32'd0);
        check("lat0_xpos1_p", 32'(z_first_x1), 32'd6344);
        check("lat43_errs", 32'(f_err), 32'd0);
        check("lat43_xpos1_p", 32'(f_first_x1), 32'd6301);
        check("small_errs", 32'(s_err), 32'd0);
        check("small_fs_count", 32'(s_fs_cnt), 32'd43);

        // Advance to v=13, h=200 (active video, row 1) then pulse reset.
        repeat (200) @(negedge clk);
        check("mid_de", 32'(m_de), 32'd1);
        check("mid_y", 32'(m_y), 32'd1);
        check("mid_x", 32'(m_x), 32'd159);
        check("mid_rgb", 32'(m_rgb), 32'h9D01A5);

        rst = 1'b1;
        @(negedge clk);
        check_reset_state("mid_rst");
        rst = 1'b0;
        @(negedge clk);
        check("restart_fs", 32'(m_fs), 32'd1);
        check("restart_hs", 32'(m_hs), 32'd0);
        check("restart_vs", 32'(m_vs), 32'd0);
        check("restart_bl", 32'(m_bl), 32'd1);
        check("restart_y", 32'(m_y), 32'd0);
        @(negedge clk);
        check("restart_fs_drop", 32'(m_fs), 32'd0);
        check("restart_hs_hold", 32'(m_hs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
